// File: rtl/div_pkg.sv
// ------------------------------------------------------------------
// div_pkg: shared FSM states and widths for the restoring divider. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int N_W_DEF = 8;
  localparam int D_W_DEF = 4;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(N_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/restoring_divider_8by4_if.sv
// ------------------------------------------------------------------
// restoring_divider_8by4_if: request/result bundle of the divider. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface restoring_divider_8by4_if
  import div_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
);

  logic           start;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           busy;
  logic           done;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ------------------------------------------------------------------
// div_step: one restoring compare/subtract on a D_W+1 bit partial remainder. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int D_W = D_W_DEF
) (
  input  wire logic [D_W:0]   i_pr,
  input  wire logic [D_W-1:0] i_divisor,
  output logic      [D_W-1:0] o_rem,
  output logic                o_qbit
);

  logic w_ge;

  assign w_ge   = (i_pr >= {1'b0, i_divisor});
  assign o_qbit = w_ge;
  // After a successful subtract the result is below the divisor, so the top bit is always zero.
  assign o_rem  = w_ge ? D_W'(i_pr - {1'b0, i_divisor}) : i_pr[D_W-1:0];

endmodule

`default_nettype wire

// File: rtl/restoring_divider_8by4.sv
// ------------------------------------------------------------------
// restoring_divider_8by4: N_W/D_W unsigned restoring divider, one quotient bit per cycle. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module restoring_divider_8by4
  import div_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input wire logic              clk,
  input wire logic              rst_n,
  restoring_divider_8by4_if.slave bus
);

  localparam int                CNT_W  = cnt_w(N_W);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(N_W - 1);
  localparam logic [CNT_W-1:0] c_max  = CNT_W'(N_W);

  state_t           r_state;
  logic [N_W-1:0]   r_q;
  logic [D_W-1:0]   r_r;
  logic [D_W-1:0]   r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [N_W-1:0]   r_quot;
  logic [D_W-1:0]   r_rem;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;

  logic [D_W:0]     w_pr;
  logic [D_W-1:0]   w_rem;
  logic             w_qbit;
  logic [N_W-1:0]   w_q_next;

  assign w_pr     = {r_r, r_q[N_W-1]};
  assign w_q_next = {r_q[N_W-2:0], w_qbit};

  div_step #(.D_W(D_W)) u_step (
    .i_pr      (w_pr),
    .i_divisor (r_div),
    .o_rem     (w_rem),
    .o_qbit    (w_qbit)
  );

  // Results latch on DONE entry; the done pulse follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_q   <= bus.dividend;
            r_div <= bus.divisor;
            r_r   <= '0;
            r_cnt <= '0;
            if (bus.divisor == '0) begin
              r_state <= DONE;
              r_quot  <= '1;
              r_rem   <= bus.dividend[D_W-1:0];
              r_dbz   <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_q <= w_q_next;
          r_r <= w_rem;
          if (r_cnt != c_max) r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_quot  <= w_q_next;
            r_rem   <= w_rem;
            r_dbz   <= 1'b0;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider_8by4.sv
// ------------------------------------------------------------------
// tb_restoring_divider_8by4: directed and exhaustive checks of the restoring divider. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_restoring_divider_8by4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  restoring_divider_8by4_if #(.N_W(8), .D_W(4)) bus ();

  restoring_divider_8by4 #(.N_W(8), .D_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One division; inj > 0 pulses a 50/3 start on the inj-th edge after acceptance.
  task automatic do_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input int exp_lat, input int exp_busy,
                        input logic [7:0] eq, input logic [3:0] er, input logic edz,
                        input int inj);
    int lat;
    int nbusy;
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    lat   = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && lat < 20) begin
      if (bus.busy) nbusy++;
      if (lat + 1 == inj) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 4'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk({tag, ".lat"},  lat,             exp_lat);
    chk({tag, ".busy"}, nbusy,           exp_busy);
    chk({tag, ".q"},    bus.quotient,    eq);
    chk({tag, ".r"},    bus.remainder,   er);
    chk({tag, ".dbz"},  bus.div_by_zero, edz);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, bus.done,       1'b0);
    chk({tag, ".hold"},  bus.quotient,   eq);
    chk({tag, ".idle"},  bus.busy,       1'b0);
  endtask

  initial begin
    int ndone;
    n_vec = 0;
    n_err = 0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", bus.busy,        1'b0);
    chk("rst.done", bus.done,        1'b0);
    chk("rst.q",    bus.quotient,    8'd0);
    chk("rst.r",    bus.remainder,   4'd0);
    chk("rst.dbz",  bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div("100/10", 8'd100, 4'd10, 9, 8, 8'd10,  4'd0, 1'b0, 0);
    do_div("200/7",  8'd200, 4'd7,  9, 8, 8'd28,  4'd4, 1'b0, 0);
    do_div("255/1",  8'd255, 4'd1,  9, 8, 8'd255, 4'd0, 1'b0, 0);
    do_div("5/15",   8'd5,   4'd15, 9, 8, 8'd0,   4'd5, 1'b0, 0);
    do_div("37/0",   8'd37,  4'd0,  1, 0, 8'hFF,  4'h5, 1'b1, 0);
    do_div("171/0",  8'd171, 4'd0,  1, 0, 8'hFF,  4'hB, 1'b1, 0);
    do_div("ign",    8'd100, 4'd10, 9, 8, 8'd10,  4'd0, 1'b0, 3);

    // Reset mid-division: outputs clear immediately and no done follows.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.busy_pre", bus.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort.busy", bus.busy,        1'b0);
    chk("abort.done", bus.done,        1'b0);
    chk("abort.q",    bus.quotient,    8'd0);
    chk("abort.r",    bus.remainder,   4'd0);
    chk("abort.dbz",  bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("abort.nodone", ndone, 0);
    do_div("15/3", 8'd15, 4'd3, 9, 8, 8'd5, 4'd0, 1'b0, 0);

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div($sformatf("ex%0d/%0d", a, b), 8'(a), 4'(b), 9, 8,
               8'(a / b), 4'(a % b), 1'b0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
